// File: rtl/branch_seq.sv
// Branch-resolution sequencer for the LEGv8 EX stage: NZVC flag register,
// PC mux select, pipeline flush pulses, wrong-path squash window and branch counters.
module branch_seq #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    input  logic             ex_IsBranch,
    input  logic             ex_SetFlags,
    input  logic [1:0]       ex_PCSrc,
    input  logic             Zero,
    input  logic             Negative,
    input  logic             Overflow,
    input  logic             Co,
    input  logic             stall_in,
    input  logic             cnt_clr,
    output logic [1:0]       PCSel,
    output logic             flush_IFID,
    output logic             flush_IDEX,
    output logic             ex_kill,
    output logic             Flag_N,
    output logic             Flag_Z,
    output logic             Flag_V,
    output logic             Flag_C,
    output logic [CNT_W-1:0] br_total,
    output logic [CNT_W-1:0] br_taken
);

    typedef enum logic {
        RUN,
        SQUASH
    } state_t;

    localparam logic [3:0] SQUASH_LOAD = 4'((FLUSH_CYCLES == 0) ? 0 : FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       act;
    logic       redirect;

    // Reset gates the combinational outputs so a reset landing mid-squash never
    // leaks a kill or a redirect into the pipeline during the reset cycle.
    always_comb begin
        act        = (state_q == RUN) && ex_valid && !stall_in && !rst;
        redirect   = act && (ex_PCSrc != 2'b00);
        PCSel      = act ? ex_PCSrc : 2'b00;
        flush_IFID = redirect;
        flush_IDEX = redirect;
        ex_kill    = (state_q == SQUASH) && !rst;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (redirect && (FLUSH_CYCLES != 0)) begin
                    state_d = SQUASH;
                    cnt_d   = SQUASH_LOAD;
                end
            end
            SQUASH: begin
                if (!stall_in) begin
                    if (cnt_q == 4'd0) begin
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            Flag_N <= 1'b0;
            Flag_Z <= 1'b0;
            Flag_V <= 1'b0;
            Flag_C <= 1'b0;
        end else if (act && ex_SetFlags) begin
            Flag_N <= Negative;
            Flag_Z <= Zero;
            Flag_V <= Overflow;
            Flag_C <= Co;
        end
    end

    // Counters saturate instead of wrapping; a clear beats a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            br_total <= '0;
            br_taken <= '0;
        end else if (act && ex_IsBranch) begin
            if (br_total != CNT_MAX) begin
                br_total <= br_total + CNT_W'(1);
            end
            if ((ex_PCSrc != 2'b00) && (br_taken != CNT_MAX)) begin
                br_taken <= br_taken + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_seq.sv
// Directed self-checking bench for branch_seq; a second instance with no
// squash window shares the stimulus.
module tb_branch_seq;

    logic       clk = 1'b0;
    logic       rst, ex_valid, ex_IsBranch, ex_SetFlags;
    logic [1:0] ex_PCSrc;
    logic       Zero, Negative, Overflow, Co, stall_in, cnt_clr;

    logic [1:0] PCSel;
    logic       flush_IFID, flush_IDEX, ex_kill;
    logic       Flag_N, Flag_Z, Flag_V, Flag_C;
    logic [3:0] br_total, br_taken;

    logic [1:0] PCSel0;
    logic       flush_IFID0, flush_IDEX0, ex_kill0;
    logic       Flag_N0, Flag_Z0, Flag_V0, Flag_C0;
    logic [3:0] br_total0, br_taken0;

    logic [3:0] nzvc;
    int checks = 0;
    int errors = 0;

    assign nzvc = {Flag_N, Flag_Z, Flag_V, Flag_C};

    always #5 clk = ~clk;

    branch_seq #(.FLUSH_CYCLES(2), .CNT_W(4)) u_dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_IsBranch(ex_IsBranch),
        .ex_SetFlags(ex_SetFlags), .ex_PCSrc(ex_PCSrc), .Zero(Zero),
        .Negative(Negative), .Overflow(Overflow), .Co(Co), .stall_in(stall_in),
        .cnt_clr(cnt_clr), .PCSel(PCSel), .flush_IFID(flush_IFID),
        .flush_IDEX(flush_IDEX), .ex_kill(ex_kill), .Flag_N(Flag_N),
        .Flag_Z(Flag_Z), .Flag_V(Flag_V), .Flag_C(Flag_C),
        .br_total(br_total), .br_taken(br_taken)
    );

    branch_seq #(.FLUSH_CYCLES(0), .CNT_W(4)) u_dut0 (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_IsBranch(ex_IsBranch),
        .ex_SetFlags(ex_SetFlags), .ex_PCSrc(ex_PCSrc), .Zero(Zero),
        .Negative(Negative), .Overflow(Overflow), .Co(Co), .stall_in(stall_in),
        .cnt_clr(cnt_clr), .PCSel(PCSel0), .flush_IFID(flush_IFID0),
        .flush_IDEX(flush_IDEX0), .ex_kill(ex_kill0), .Flag_N(Flag_N0),
        .Flag_Z(Flag_Z0), .Flag_V(Flag_V0), .Flag_C(Flag_C0),
        .br_total(br_total0), .br_taken(br_taken0)
    );

    // Advance one clock, then settle just past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ex_valid = 0; ex_IsBranch = 0; ex_SetFlags = 0; ex_PCSrc = 2'b00;
        Zero = 0; Negative = 0; Overflow = 0; Co = 0; stall_in = 0; cnt_clr = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        ex_valid = 1; ex_PCSrc = 2'b01;
        #1;
        checks++;
        if ({PCSel, flush_IFID, flush_IDEX, ex_kill} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL reset_cycle_outputs: got %b required 00000",
                     {PCSel, flush_IFID, flush_IDEX, ex_kill});
        end
        tick();
        idle_inputs();
        rst = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({PCSel, flush_IFID, flush_IDEX, ex_kill} !== 5'b0) begin
                errors++;
                $display("[TB] FAIL idle_outputs cycle %0d: got %b required 00000", i,
                         {PCSel, flush_IFID, flush_IDEX, ex_kill});
            end
        end
        checks++;
        if ({nzvc, br_total, br_taken} !== 12'h000) begin
            errors++;
            $display("[TB] FAIL reset_state: got nzvc=%b total=%0d taken=%0d required 0000/0/0",
                     nzvc, br_total, br_taken);
        end
    endtask

    task automatic test_flags_then_branch();
        do_reset();
        ex_valid = 1; ex_SetFlags = 1; Negative = 0; Zero = 1; Overflow = 0; Co = 1;
        tick();
        checks++;
        if (nzvc !== 4'b0101) begin
            errors++;
            $display("[TB] FAIL subs_flags: got %b required 0101", nzvc);
        end
        ex_SetFlags = 0; ex_IsBranch = 1; ex_PCSrc = 2'b01;
        Negative = 1; Zero = 1; Overflow = 1; Co = 1;
        #1;
        checks++;
        if ({PCSel, flush_IFID, flush_IDEX} !== 4'b0111) begin
            errors++;
            $display("[TB] FAIL bcond_redirect: got PCSel/flushes %b required 0111",
                     {PCSel, flush_IFID, flush_IDEX});
        end
        tick();
        // Wrong-path traffic inside the window must be ignored.
        ex_SetFlags = 1; ex_PCSrc = 2'b10;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if ({ex_kill, PCSel, flush_IFID, flush_IDEX} !== 5'b10000) begin
                errors++;
                $display("[TB] FAIL squash_window cycle %0d: got kill/PCSel/flushes %b required 10000",
                         i, {ex_kill, PCSel, flush_IFID, flush_IDEX});
            end
            tick();
        end
        idle_inputs();
        #1;
        checks++;
        if (ex_kill !== 1'b0) begin
            errors++;
            $display("[TB] FAIL squash_end: got ex_kill=%b required 0", ex_kill);
        end
        checks++;
        if ({nzvc, br_total, br_taken} !== {4'b0101, 4'd1, 4'd1}) begin
            errors++;
            $display("[TB] FAIL after_bcond: got nzvc=%b total=%0d taken=%0d required 0101/1/1",
                     nzvc, br_total, br_taken);
        end
    endtask

    task automatic test_stall_in_squash();
        do_reset();
        ex_valid = 1; ex_SetFlags = 1; Negative = 1; Zero = 0; Overflow = 1; Co = 0;
        tick();
        ex_SetFlags = 0; ex_PCSrc = 2'b01;
        tick();
        stall_in = 1; ex_SetFlags = 1; Negative = 0; Zero = 1; Overflow = 0; Co = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (ex_kill !== 1'b1) begin
                errors++;
                $display("[TB] FAIL stalled_squash cycle %0d: got ex_kill=%b required 1", i, ex_kill);
            end
            tick();
            stall_in = 0;
        end
        idle_inputs();
        #1;
        checks++;
        if (ex_kill !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stalled_squash_end: got ex_kill=%b required 0", ex_kill);
        end
        checks++;
        if ({nzvc, br_total} !== {4'b1010, 4'd0}) begin
            errors++;
            $display("[TB] FAIL squash_flag_hold: got nzvc=%b total=%0d required 1010/0",
                     nzvc, br_total);
        end
    endtask

    task automatic test_untaken_branch();
        do_reset();
        ex_valid = 1; ex_IsBranch = 1; ex_PCSrc = 2'b00;
        #1;
        checks++;
        if ({PCSel, flush_IFID, flush_IDEX} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL untaken_outputs: got %b required 0000",
                     {PCSel, flush_IFID, flush_IDEX});
        end
        tick();
        checks++;
        if ({br_total, br_taken, ex_kill} !== {4'd1, 4'd0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL untaken_count: got total=%0d taken=%0d kill=%b required 1/0/0",
                     br_total, br_taken, ex_kill);
        end
        stall_in = 1; ex_PCSrc = 2'b01;
        #1;
        checks++;
        if ({PCSel, flush_IFID} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL stall_outputs: got %b required 000", {PCSel, flush_IFID});
        end
        tick();
        checks++;
        if ({br_total, br_taken, ex_kill} !== {4'd1, 4'd0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL stall_count: got total=%0d taken=%0d kill=%b required 1/0/0",
                     br_total, br_taken, ex_kill);
        end
        idle_inputs();
    endtask

    task automatic test_saturation();
        int exp_cnt;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            ex_valid = 1; ex_IsBranch = 1; ex_PCSrc = 2'b01;
            tick();
            ex_valid = 0;
            tick();
            tick();
            exp_cnt = (i + 1 > 15) ? 15 : i + 1;
            checks++;
            if (br_total !== 4'(exp_cnt) || br_taken !== 4'(exp_cnt)) begin
                errors++;
                $display("[TB] FAIL saturate iter %0d: got total=%0d taken=%0d required %0d",
                         i, br_total, br_taken, exp_cnt);
            end
        end
        ex_valid = 1; ex_IsBranch = 1; ex_PCSrc = 2'b01; cnt_clr = 1;
        tick();
        cnt_clr = 0; ex_valid = 0;
        checks++;
        if ({br_total, br_taken} !== 8'h00) begin
            errors++;
            $display("[TB] FAIL clear_priority: got total=%0d taken=%0d required 0/0",
                     br_total, br_taken);
        end
        checks++;
        if (ex_kill !== 1'b1) begin
            errors++;
            $display("[TB] FAIL clear_keeps_state: got ex_kill=%b required 1", ex_kill);
        end
        tick();
        tick();
        idle_inputs();
    endtask

    task automatic test_reset_in_squash();
        do_reset();
        ex_valid = 1; ex_SetFlags = 1; Negative = 1; Zero = 1; Overflow = 1; Co = 1;
        ex_IsBranch = 1; ex_PCSrc = 2'b01;
        tick();
        idle_inputs();
        #1;
        checks++;
        if ({ex_kill, nzvc, br_total} !== {1'b1, 4'b1111, 4'd1}) begin
            errors++;
            $display("[TB] FAIL pre_reset_squash: got kill=%b nzvc=%b total=%0d required 1/1111/1",
                     ex_kill, nzvc, br_total);
        end
        rst = 1;
        #1;
        checks++;
        if (ex_kill !== 1'b0) begin
            errors++;
            $display("[TB] FAIL kill_during_reset: got %b required 0", ex_kill);
        end
        tick();
        rst = 0;
        checks++;
        if ({ex_kill, nzvc, br_total, br_taken} !== 13'h0) begin
            errors++;
            $display("[TB] FAIL post_reset: got kill=%b nzvc=%b total=%0d taken=%0d required 0/0000/0/0",
                     ex_kill, nzvc, br_total, br_taken);
        end
        ex_valid = 1; ex_PCSrc = 2'b10;
        #1;
        checks++;
        if ({PCSel, flush_IFID, flush_IDEX} !== 4'b1011) begin
            errors++;
            $display("[TB] FAIL post_reset_redirect: got %b required 1011",
                     {PCSel, flush_IFID, flush_IDEX});
        end
        tick();
        idle_inputs();
        tick();
        tick();
    endtask

    task automatic test_no_squash_window();
        do_reset();
        ex_valid = 1; ex_PCSrc = 2'b11;
        tick();
        ex_PCSrc = 2'b10;
        #1;
        checks++;
        if ({ex_kill0, PCSel0, flush_IDEX0} !== 4'b0101) begin
            errors++;
            $display("[TB] FAIL zero_window: got kill/PCSel/flush %b required 0101",
                     {ex_kill0, PCSel0, flush_IDEX0});
        end
        checks++;
        if ({ex_kill, PCSel} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL hold_redirect_squash: got kill/PCSel %b required 100",
                     {ex_kill, PCSel});
        end
        idle_inputs();
        tick();
        tick();
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        tick();
        test_reset();
        test_flags_then_branch();
        test_stall_in_squash();
        test_untaken_branch();
        test_saturation();
        test_reset_in_squash();
        test_no_squash_window();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
